// File: rtl/video_pkg.sv
//==============================================================================
// Module      : video_pkg
// Description : Shared video-path types: coordinate width, default raster
//               size and the stream-beat record.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package video_pkg;

    localparam int c_coord_w   = 13;
    localparam int c_scrw_def  = 1280;
    localparam int c_scrh_def  = 720;
    localparam int c_vid_dataw = 32;

    typedef logic [c_coord_w-1:0] coord_t;

    typedef struct packed {
        logic [c_vid_dataw-1:0] data;
        logic                   user;
        logic                   last;
    } beat_t;

    function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/video_box_overlay_if.sv
//==============================================================================
// Module      : video_box_overlay_if
// Description : AXI4-Stream video bundle with producer/consumer modports.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface video_box_overlay_if #(
    parameter int DATAW = 32
) ();

    logic [DATAW-1:0]   tdata;
    logic               tvalid;
    logic               tready;
    logic               tuser;
    logic               tlast;
    logic [DATAW/8-1:0] tstrb;
    logic [DATAW/8-1:0] tkeep;
    logic               tid;
    logic               tdest;

    modport master (
        output tdata, tvalid, tuser, tlast, tstrb, tkeep, tid, tdest,
        input  tready
    );

    // Upstream pattern generator carries no strobe/keep/id/dest fields.
    modport slave (
        input  tdata, tvalid, tuser, tlast,
        output tready
    );

endinterface

`default_nettype wire

// File: rtl/video_box_overlay_skid.sv
//==============================================================================
// Module      : axis_skid_slice
// Description : Two-entry (main + skid) register slice with a registered
//               upstream ready, full throughput and one cycle of latency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_skid_slice #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_s_ready;

    logic [WIDTH-1:0] w_main_data_nx;
    logic [WIDTH-1:0] w_skid_data_nx;
    logic             w_main_valid_nx;
    logic             w_skid_valid_nx;
    logic             w_s_fire;

    always_comb begin
        w_s_fire        = s_valid && r_s_ready;
        w_main_data_nx  = r_main_data;
        w_skid_data_nx  = r_skid_data;
        w_main_valid_nx = r_main_valid;
        w_skid_valid_nx = r_skid_valid;

        if (!r_main_valid || m_ready) begin
            // Main slot frees up: refill from skid first to keep ordering.
            if (r_skid_valid) begin
                w_main_data_nx  = r_skid_data;
                w_main_valid_nx = 1'b1;
                w_skid_valid_nx = 1'b0;
            end else begin
                w_main_valid_nx = w_s_fire;
                if (w_s_fire) begin
                    w_main_data_nx = s_data;
                end
            end
        end else if (w_s_fire) begin
            w_skid_data_nx  = s_data;
            w_skid_valid_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_s_ready    <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_s_ready    <= !w_skid_valid_nx;
        end
    end

    always_ff @(posedge clk) begin
        r_main_data <= w_main_data_nx;
        r_skid_data <= w_skid_data_nx;
    end

    assign s_ready = r_s_ready;
    assign m_data  = r_main_data;
    assign m_valid = r_main_valid;

endmodule

`default_nettype wire

// File: rtl/video_box_overlay.sv
//==============================================================================
// Module      : video_box_overlay
// Description : Tracks raster position on an AXI4-Stream video feed and paints
//               the border of a programmable rectangle; flags bad line lengths.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module video_box_overlay
    import video_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int SCRW  = c_scrw_def,
    parameter int SCRH  = c_scrh_def,
    parameter int THICK = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  coord_t               box_x0,
    input  coord_t               box_y0,
    input  coord_t               box_x1,
    input  coord_t               box_y1,
    input  logic [DATAW-1:0]     box_color,
    video_box_overlay_if.slave   s_axis,
    video_box_overlay_if.master  m_axis,
    output logic                 eol_early,
    output logic                 eol_late,
    output logic [15:0]          frame_cnt
);

    localparam coord_t c_x_last = coord_t'(SCRW - 1);
    localparam coord_t c_y_last = coord_t'(SCRH - 1);
    localparam coord_t c_y_sat  = coord_t'(SCRH);
    localparam logic [c_coord_w:0] c_thick = (c_coord_w + 1)'(THICK);

    // Position and SOF-shadowed configuration
    coord_t           r_x;
    coord_t           r_y;
    logic             r_en;
    coord_t           r_x0;
    coord_t           r_y0;
    coord_t           r_x1;
    coord_t           r_y1;
    logic [DATAW-1:0] r_color;
    logic             r_eol_early;
    logic             r_eol_late;
    logic [15:0]      r_frame_cnt;

    logic             w_s_ready;
    logic             w_s_fire;
    coord_t           w_cx;
    coord_t           w_cy;
    logic             w_en;
    coord_t           w_x0;
    coord_t           w_y0;
    coord_t           w_x1;
    coord_t           w_y1;
    logic [DATAW-1:0] w_color;
    logic             w_edge;
    logic             w_border;
    logic [DATAW-1:0] w_data;
    logic [DATAW+1:0] w_slice_in;
    logic [DATAW+1:0] w_slice_out;
    logic             w_m_valid;

    // An SOF beat is pixel (0,0) and sees the live config, not the stale shadow.
    always_comb begin
        w_s_fire = s_axis.tvalid && w_s_ready;
        w_cx     = s_axis.tuser ? '0 : r_x;
        w_cy     = s_axis.tuser ? '0 : r_y;
        w_en     = s_axis.tuser ? en        : r_en;
        w_x0     = s_axis.tuser ? box_x0    : r_x0;
        w_y0     = s_axis.tuser ? box_y0    : r_y0;
        w_x1     = s_axis.tuser ? box_x1    : r_x1;
        w_y1     = s_axis.tuser ? box_y1    : r_y1;
        w_color  = s_axis.tuser ? box_color : r_color;

        // x > x1-THICK rewritten as x+THICK > x1 so small x1 cannot wrap.
        w_edge = ({1'b0, w_cx} < ({1'b0, w_x0} + c_thick)) ||
                 (({1'b0, w_cx} + c_thick) > {1'b0, w_x1}) ||
                 ({1'b0, w_cy} < ({1'b0, w_y0} + c_thick)) ||
                 (({1'b0, w_cy} + c_thick) > {1'b0, w_y1});

        w_border = w_en && (w_cy < c_y_sat) &&
                   in_span(w_cx, w_x0, w_x1) &&
                   in_span(w_cy, w_y0, w_y1) && w_edge;

        w_data     = w_border ? w_color : s_axis.tdata;
        w_slice_in = {w_data, s_axis.tuser, s_axis.tlast};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_en        <= 1'b0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_color     <= '0;
            r_eol_early <= 1'b0;
            r_eol_late  <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_s_fire) begin
            if (s_axis.tuser) begin
                r_en    <= en;
                r_x0    <= box_x0;
                r_y0    <= box_y0;
                r_x1    <= box_x1;
                r_y1    <= box_y1;
                r_color <= box_color;
            end

            if (s_axis.tlast) begin
                r_x <= '0;
                r_y <= (w_cy >= c_y_last) ? c_y_sat : w_cy + coord_t'(1);
            end else begin
                r_x <= w_cx + coord_t'(1);
                r_y <= w_cy;
            end

            if (s_axis.tlast && (w_cx != c_x_last)) begin
                r_eol_early <= 1'b1;
            end
            if (!s_axis.tlast && (w_cx == c_x_last)) begin
                r_eol_late <= 1'b1;
            end
            if (s_axis.tlast && (w_cy == c_y_last)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    axis_skid_slice #(
        .WIDTH (DATAW + 2)
    ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .s_data  (w_slice_in),
        .s_valid (s_axis.tvalid),
        .s_ready (w_s_ready),
        .m_data  (w_slice_out),
        .m_valid (w_m_valid),
        .m_ready (m_axis.tready)
    );

    assign s_axis.tready = w_s_ready;

    assign {m_axis.tdata, m_axis.tuser, m_axis.tlast} = w_slice_out;
    assign m_axis.tvalid = w_m_valid;
    assign m_axis.tstrb  = '1;
    assign m_axis.tkeep  = '1;
    assign m_axis.tid    = 1'b0;
    assign m_axis.tdest  = 1'b0;

    assign eol_early = r_eol_early;
    assign eol_late  = r_eol_late;
    assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_video_box_overlay.sv
//==============================================================================
// Module      : tb_video_box_overlay
// Description : Randomized self-checking bench for video_box_overlay against a
//               raster-level reference model and an in-order scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_video_box_overlay;
    import video_pkg::*;

    localparam int c_scrw  = 128;
    localparam int c_scrh  = 48;
    localparam int c_thick = 2;
    localparam logic [31:0] c_red = 32'h00FF0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cfg_en;
    coord_t      cfg_x0, cfg_y0, cfg_x1, cfg_y1;
    logic [31:0] cfg_color;
    logic        eol_early, eol_late;
    logic [15:0] frame_cnt;

    video_box_overlay_if #(.DATAW(32)) s_if ();
    video_box_overlay_if #(.DATAW(32)) m_if ();

    video_box_overlay #(
        .DATAW (32),
        .SCRW  (c_scrw),
        .SCRH  (c_scrh),
        .THICK (c_thick)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (cfg_en),
        .box_x0    (cfg_x0),
        .box_y0    (cfg_y0),
        .box_x1    (cfg_x1),
        .box_y1    (cfg_y1),
        .box_color (cfg_color),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .eol_early (eol_early),
        .eol_late  (eol_late),
        .frame_cnt (frame_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: raster position, SOF shadow, sticky flags, frame count
    typedef struct {
        bit          en;
        int          x0, y0, x1, y1;
        logic [31:0] color;
    } cfg_t;

    typedef struct {
        beat_t       b;
        logic [31:0] orig;
        int          x, y;
        longint      t_acc;
    } exp_t;

    exp_t        q[$];
    cfg_t        mcfg;
    int          mx, my;
    bit          exp_early, exp_late;
    logic [15:0] exp_frames;

    int  rdy_mode;
    bit  rnd_valid, chk_lat, spot_on;
    int  border_cnt;

    int spot_x[5]   = '{20, 21, 69, 22, 40};
    int spot_y[5]   = '{10, 30, 44, 30, 12};
    bit spot_exp[5] = '{1, 1, 1, 0, 0};

    function automatic bit is_border(int x, int y, cfg_t c);
        if (!c.en || y >= c_scrh) return 1'b0;
        if (x < c.x0 || x > c.x1 || y < c.y0 || y > c.y1) return 1'b0;
        return (x < c.x0 + c_thick) || (x > c.x1 - c_thick) ||
               (y < c.y0 + c_thick) || (y > c.y1 - c_thick);
    endfunction

    task automatic model_reset();
        q.delete();
        mx = 0; my = 0;
        mcfg.en = 1'b0;
        exp_early = 1'b0; exp_late = 1'b0; exp_frames = '0;
    endtask

    task automatic model_accept(input logic [31:0] d, input bit u, input bit l);
        exp_t e;
        if (u) begin
            mx = 0; my = 0;
            mcfg.en = cfg_en; mcfg.color = cfg_color;
            mcfg.x0 = int'(cfg_x0); mcfg.y0 = int'(cfg_y0);
            mcfg.x1 = int'(cfg_x1); mcfg.y1 = int'(cfg_y1);
        end
        e.b.data = is_border(mx, my, mcfg) ? mcfg.color : d;
        e.b.user = u;
        e.b.last = l;
        e.orig   = d;
        e.x      = mx;
        e.y      = my;
        e.t_acc  = longint'($time);
        q.push_back(e);
        if (l && mx != c_scrw - 1)  exp_early = 1'b1;
        if (!l && mx == c_scrw - 1) exp_late  = 1'b1;
        if (l && my == c_scrh - 1)  exp_frames = exp_frames + 16'd1;
        if (l) begin
            mx = 0;
            my = (my + 1 > c_scrh) ? c_scrh : my + 1;
        end else begin
            mx++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic put_beat(input logic [31:0] d, input bit u, input bit l);
        int g = 0;
        while (rnd_valid && ($urandom_range(0, 1) == 0)) begin
            s_if.tvalid = 1'b0;
            @(negedge clk);
        end
        s_if.tdata = d; s_if.tuser = u; s_if.tlast = l; s_if.tvalid = 1'b1;
        while (!s_if.tready) begin
            @(negedge clk);
            g++;
            if (g > 500) begin
                check_val("s_ready_timeout", s_if.tready, 1);
                $fatal(1, "input side stuck");
            end
        end
        @(posedge clk);
        model_accept(d, u, l);
        @(negedge clk);
        s_if.tvalid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_pix();
        logic [31:0] d = $urandom;
        if (d == cfg_color) d = d ^ 32'h1;
        return d;
    endfunction

    task automatic send_line(input int len, input bit sof, input bit last_at_end);
        for (int i = 0; i < len; i++)
            put_beat(rnd_pix(), sof && (i == 0), last_at_end && (i == len - 1));
    endtask

    task automatic send_frame(input int chg_line, input int chg_x0);
        for (int y = 0; y < c_scrh; y++) begin
            if (y == chg_line) cfg_x0 = coord_t'(chg_x0);
            for (int x = 0; x < c_scrw; x++)
                put_beat(rnd_pix(), (x == 0) && (y == 0), x == c_scrw - 1);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check_val("drain_empty", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Output monitor: drives m tready at negedge, samples 1ns before posedge.
    initial begin
        bit          prev_stall = 1'b0;
        exp_t        e;
        m_if.tready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'($urandom_range(0, 1));
                default: m_if.tready = 1'b0;
            endcase
            #4;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check_val("hold_valid", m_if.tvalid, 1);
                if (q.size() == 2) check_val("skid_full_ready", s_if.tready, 0);
                if (m_if.tvalid) begin
                    if (q.size() == 0) begin
                        check_val("spurious_valid", m_if.tvalid, 0);
                    end else begin
                        e = q[0];
                        check_val("pix", {m_if.tdata, m_if.tuser, m_if.tlast}, e.b);
                        if (m_if.tready) begin
                            void'(q.pop_front());
                            if (chk_lat)
                                check_val("latency", 64'(longint'($time) + 1 - e.t_acc), 10);
                            if (m_if.tdata != e.orig) border_cnt++;
                            if (spot_on)
                                for (int i = 0; i < 5; i++)
                                    if (e.x == spot_x[i] && e.y == spot_y[i])
                                        check_val("spot", m_if.tdata == c_red, spot_exp[i]);
                        end
                    end
                end
                prev_stall = m_if.tvalid && !m_if.tready;
            end
        end
    end

    task automatic check_status(input string tag);
        check_val({tag, "_frame_cnt"}, frame_cnt, exp_frames);
        check_val({tag, "_eol_early"}, eol_early, exp_early);
        check_val({tag, "_eol_late"},  eol_late,  exp_late);
    endtask

    initial begin
        rst = 1'b1;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
        s_if.tstrb = '1; s_if.tkeep = '1; s_if.tid = 1'b0; s_if.tdest = 1'b0;
        cfg_en = 1'b0; cfg_x0 = '0; cfg_y0 = '0; cfg_x1 = '0; cfg_y1 = '0; cfg_color = '0;
        rdy_mode = 0; rnd_valid = 1'b0; chk_lat = 1'b0; spot_on = 1'b0; border_cnt = 0;
        model_reset();

        repeat (3) @(negedge clk);
        check_val("rst_s_ready", s_if.tready, 0);
        check_val("rst_m_valid", m_if.tvalid, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("s_ready_after_rst", s_if.tready, 1);
        check_val("tkeep", m_if.tkeep, 4'hF);
        check_val("tstrb", m_if.tstrb, 4'hF);
        check_val("tid_tdest", {m_if.tid, m_if.tdest}, 0);
        check_status("reset");

        // Pass-through frame, overlay disabled
        chk_lat = 1'b1;
        send_frame(-1, 0);
        drain();
        check_status("passthru");
        check_val("passthru_frames", frame_cnt, 1);

        // Box (20,10)-(69,44), border of 2
        cfg_en = 1'b1; cfg_color = c_red;
        cfg_x0 = 13'd20; cfg_y0 = 13'd10; cfg_x1 = 13'd69; cfg_y1 = 13'd44;
        border_cnt = 0; spot_on = 1'b1;
        send_frame(-1, 0);
        drain();
        spot_on = 1'b0;
        check_val("border_cnt_box", border_cnt, 324);

        // Mid-frame x0 change must wait for the next SOF
        border_cnt = 0;
        send_frame(c_scrh / 2, 60);
        drain();
        check_val("border_cnt_midchg", border_cnt, 324);
        border_cnt = 0;
        send_frame(-1, 0);
        drain();
        check_val("border_cnt_newcfg", border_cnt, 164);
        check_status("overlay");

        // Random valid/ready over two frames with a random box
        chk_lat = 1'b0; rnd_valid = 1'b1; rdy_mode = 1;
        for (int f = 0; f < 2; f++) begin
            cfg_x0 = coord_t'($urandom_range(0, 140)); cfg_x1 = coord_t'($urandom_range(0, 140));
            cfg_y0 = coord_t'($urandom_range(0, 56));  cfg_y1 = coord_t'($urandom_range(0, 56));
            cfg_color = $urandom;
            send_frame(-1, 0);
        end
        drain();
        check_status("random");
        rnd_valid = 1'b0; rdy_mode = 0; chk_lat = 1'b1;

        // Malformed line lengths
        send_line(100, 1'b1, 1'b1);
        drain();
        check_val("short_line_early", eol_early, 1);
        check_status("short_line");
        send_line(c_scrw + 1, 1'b0, 1'b1);
        drain();
        check_val("long_line_late", eol_late, 1);
        check_status("long_line");
        send_frame(-1, 0);
        drain();
        check_status("sticky");

        // Reset with one beat parked in the skid entry
        rdy_mode = 2;
        @(negedge clk);
        put_beat(rnd_pix(), 1'b1, 1'b0);
        put_beat(rnd_pix(), 1'b0, 1'b0);
        check_val("skid_full_s_ready", s_if.tready, 0);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_val("midrst_m_valid", m_if.tvalid, 0);
        check_val("midrst_frame_cnt", frame_cnt, 0);
        check_status("midrst");
        rst = 1'b0; rdy_mode = 0;
        @(negedge clk);
        cfg_en = 1'b1; cfg_color = c_red;
        cfg_x0 = 13'd20; cfg_y0 = 13'd10; cfg_x1 = 13'd69; cfg_y1 = 13'd44;
        border_cnt = 0;
        send_frame(-1, 0);
        drain();
        check_val("restart_border_cnt", border_cnt, 324);
        check_status("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
